// File: rtl/diffeq_if.sv
// Operand/result bundle between the solver sequencer and its host.
// The host drives start and the operands; the sequencer returns state and status.
interface diffeq_if #(
    parameter int WIDTH  = 32,
    parameter int ITER_W = 16
);
    logic              start;
    logic [WIDTH-1:0]  aport;
    logic [WIDTH-1:0]  dxport;
    logic [WIDTH-1:0]  x_init;
    logic [WIDTH-1:0]  y_init;
    logic [WIDTH-1:0]  u_init;
    logic [WIDTH-1:0]  xport;
    logic [WIDTH-1:0]  yport;
    logic [WIDTH-1:0]  uport;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [ITER_W-1:0] iter_count;

    modport master (
        output start, aport, dxport, x_init, y_init, u_init,
        input  xport, yport, uport, busy, done, overflow, iter_count
    );

    modport slave (
        input  start, aport, dxport, x_init, y_init, u_init,
        output xport, yport, uport, busy, done, overflow, iter_count
    );
endinterface

// File: rtl/diffeq_seq_ctrl.sv
// Euler-step differential-equation solver with one shared multiplier, three
// multiply steps per iteration, start/done handshake and an iteration guard.
module diffeq_seq_ctrl #(
    parameter int WIDTH    = 32,
    parameter int ITER_W   = 16,
    parameter int MAX_ITER = 1024
) (
    input  logic     clk,
    input  logic     reset,
    diffeq_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, CHECK, MUL1, MUL2, MUL3, UPDATE, DONE
    } state_t;

    localparam logic [ITER_W-1:0] MAX_ITER_C = ITER_W'(MAX_ITER);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, dx_q, dx_d;
    logic [WIDTH-1:0]  x_q, x_d, y_q, y_d, u_q, u_d;
    logic [WIDTH-1:0]  t_q, t_d, p1_q, p1_d, p2_q, p2_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              ovf_q, ovf_d;

    logic [WIDTH-1:0]  mul_a, mul_b, mul_p;
    logic [WIDTH-1:0]  x5, y3;

    assign x5 = (x_q << 2) + x_q;
    assign y3 = (y_q << 1) + y_q;

    // Operand select for the single shared multiplier; product keeps the low WIDTH bits.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            MUL1:    begin mul_a = u_q;  mul_b = dx_q; end
            MUL2:    begin mul_a = t_q;  mul_b = x5;   end
            MUL3:    begin mul_a = dx_q; mul_b = y3;   end
            default: begin mul_a = '0;   mul_b = '0;   end
        endcase
    end

    assign mul_p = mul_a * mul_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            dx_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            u_q     <= '0;
            t_q     <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            iter_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            dx_q    <= dx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            u_q     <= u_d;
            t_q     <= t_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            iter_q  <= iter_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        dx_d    = dx_q;
        x_d     = x_q;
        y_d     = y_q;
        u_d     = u_q;
        t_d     = t_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        iter_d  = iter_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.aport;
                    dx_d    = bus.dxport;
                    x_d     = bus.x_init;
                    y_d     = bus.y_init;
                    u_d     = bus.u_init;
                    iter_d  = '0;
                    ovf_d   = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (x_q < a_q) begin
                    if (iter_q < MAX_ITER_C) begin
                        state_d = MUL1;
                    end else begin
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            MUL1: begin
                t_d     = mul_p;
                state_d = MUL2;
            end
            MUL2: begin
                p1_d    = mul_p;
                state_d = MUL3;
            end
            MUL3: begin
                p2_d    = mul_p;
                state_d = UPDATE;
            end
            UPDATE: begin
                // Every right-hand side uses the pre-update x, y and u.
                x_d     = x_q + dx_q;
                y_d     = y_q + t_q;
                u_d     = u_q - p1_q - p2_q;
                iter_d  = iter_q + 1'b1;
                state_d = CHECK;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.xport      = x_q;
    assign bus.yport      = y_q;
    assign bus.uport      = u_q;
    assign bus.iter_count = iter_q;
    assign bus.overflow   = ovf_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
endmodule

// File: doc/diffeq_seq_ctrl.md
# diffeq_seq_ctrl

Multi-cycle sequencer for the differential-equation solver datapath. It runs the Euler update x += dx, y += u·dx, u -= u·dx·5x + dx·3y until x ≥ a, using one shared WIDTH×WIDTH multiplier time-multiplexed over three multiply steps per iteration. It replaces the single-cycle, three-multiplier solver where multiplier area matters, and adds a start/done handshake, an iteration counter and a runaway guard.

## Interface
- WIDTH, 32, datapath width for a, dx, x, y and u.
- ITER_W, 16, iteration counter width.
- MAX_ITER, 1024, iteration limit before forced termination. Must be less than 2^ITER_W.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse that loads the operands and begins a solve. Ignored unless the FSM is in IDLE.
- aport  in  WIDTH  x bound, latched on an accepted start.
- dxport  in  WIDTH  step size, latched on an accepted start.
- x_init, y_init, u_init  in  WIDTH each  initial state, latched on an accepted start.
- xport, yport, uport  out  WIDTH each  registered solver state; holds the final values after done.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in state DONE.
- overflow  out  1  set in DONE if the solve stopped because of MAX_ITER; cleared on the next accepted start.
- iter_count  out  ITER_W  number of completed iterations; cleared on an accepted start.

## Operation
- **States:** IDLE, CHECK, MUL1, MUL2, MUL3, UPDATE, DONE.
- **IDLE:**
  - On start=1: latch aport into a_r and dxport into dx_r, load xport/yport/uport from x_init/y_init/u_init, clear iter_count and overflow, then go to CHECK.
- **CHECK:**
  - If xport < a_r (unsigned) and iter_count < MAX_ITER: go to MUL1.
  - Else if xport < a_r: set overflow and go to DONE.
  - Else: go to DONE.
- **Multiply steps:** one shared multiplier, operands selected by state; the product is truncated to the low WIDTH bits and registered.
  - MUL1: t_r ← uport·dx_r.
  - MUL2: p1_r ← t_r·x5, where x5 = (xport<<2)+xport.
  - MUL3: p2_r ← dx_r·y3, where y3 = (yport<<1)+yport.
- **UPDATE:** all three assignments use the pre-update x, y and u, then the FSM goes to CHECK.
  - xport ← xport + dx_r.
  - yport ← yport + t_r.
  - uport ← uport − p1_r − p2_r.
  - iter_count ← iter_count + 1.
- **DONE:** done=1, then go to IDLE.
- **Arithmetic:** all arithmetic is modulo 2^WIDTH with no saturation.
- **Output stability:** xport, yport and uport change only on an accepted start or in UPDATE.
- **Live inputs:** changes on aport or dxport while busy have no effect.
- **start while busy or in DONE:** ignored, not queued.
- **dx = 0 with x < a:** the loop never exits by the bound, so the MAX_ITER guard terminates it.
- **iter_count wrap:** cannot occur, because MAX_ITER < 2^ITER_W.

## Timing
- **Reset:** reset=1 at a clock edge forces the FSM to IDLE and clears xport, yport, uport, t_r, p1_r, p2_r, a_r, dx_r, iter_count, busy, done and overflow. This applies in any state, including mid-solve; no done is produced for the aborted solve.
- **Latency:** let the start be sampled at edge k and the solve run N iterations.
  - CHECK occurs in cycle k+1.
  - Each iteration takes exactly 5 cycles (CHECK, MUL1, MUL2, MUL3, UPDATE).
  - done is high in cycle k+2+5N.
  - busy is high from cycle k+1 through cycle k+2+5N.
- **Restart:** earliest next accepted start is in the cycle after done.
- **Simultaneous reset and start:** reset wins.

## Test plan
- **Reset values:** assert reset for 2 cycles mid-solve → all outputs are 0, FSM in IDLE, and no done pulse follows.
- **Two iterations:** a=2, dx=1, x_init=0, y_init=1, u_init=1 →
  - after iteration 1: u=0xFFFFFFFE.
  - final: x=2, y=0, u=2, iter_count=2, overflow=0.
  - done is high exactly 12 cycles after the start edge.
- **Zero iterations:** x_init=5, a=5 → done 2 cycles after start, iter_count=0, and x/y/u equal their init values.
- **Runaway guard:** MAX_ITER=4, dx=0, a=10, x_init=0 → done at start+22, overflow=1, iter_count=4.
- **Ignored start:** pulse start and change aport mid-solve in the two-iteration case → the result is unchanged (x=2, y=0, u=2) and exactly one done pulse occurs.
- **Wrap:** a=0xFFFFFFFF, dx=0x80000000, x_init=0x7FFFFFFF, y_init=0, u_init=0 →
  - after one iteration: x=0xFFFFFFFF, iter_count=1.
  - the next CHECK sees x ≥ a and terminates, with done at start+7 and overflow=0.
